// File: rtl/qlm_pkg.sv
// Shared helpers for the pipelined approximate log multiplier.
// The width derivations live here so the top module and the encoder agree on them.
package qlm_pkg;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a leading-one index for an n-bit magnitude.
    function automatic int unsigned kw_of(input int unsigned n);
        return clog2(n);
    endfunction

    // Width of the log-domain sum {k, f} + {k, f}, which cannot overflow.
    function automatic int unsigned lw_of(input int unsigned n, input int unsigned mw);
        return clog2(n) + 1 + mw;
    endfunction

endpackage

// File: rtl/qlm_lod_enc.sv
// Leading-one detector with truncated mantissa extraction for one operand magnitude.
// Purely combinational; the pipeline registers its outputs.
module qlm_lod_enc import qlm_pkg::*; #(
    parameter int unsigned N = 8,
    parameter int unsigned MW = 4,
    localparam int unsigned KW = kw_of(N)
) (
    input  logic [N-1:0]  mag,
    output logic          zero,
    output logic [KW-1:0] k,
    output logic [MW-1:0] f
);

    assign zero = (mag == '0);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (mag[i]) begin
                k = KW'(i);
            end
        end
    end

    // Append MW zeros so bits below the leading one shift into f, zero-padded on the right.
    assign f = MW'({mag, {MW{1'b0}}} >> k);

endmodule

// File: rtl/qlm_pipe_mult.sv
// Three-stage valid/ready Mitchell-style log multiplier with a per-operation exact mode.
// Tag and mode travel with each operation; one global advance signal stalls every stage.
module qlm_pipe_mult import qlm_pkg::*; #(
    parameter int unsigned N = 8,
    parameter int unsigned MW = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic             in_exact,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exact
);

    localparam int unsigned KW = kw_of(N);
    localparam int unsigned LW = lw_of(N, MW);
    localparam int unsigned PW = 2 * N + MW;

    logic adv;

    logic [N-1:0]   mag_x;
    logic [N-1:0]   mag_y;
    logic           zero_x;
    logic           zero_y;
    logic [KW-1:0]  k_x;
    logic [KW-1:0]  k_y;
    logic [MW-1:0]  f_x;
    logic [MW-1:0]  f_y;
    logic [2*N-1:0] prod;

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_zero;
    logic             s1_exact;
    logic [KW-1:0]    s1_kx;
    logic [KW-1:0]    s1_ky;
    logic [MW-1:0]    s1_fx;
    logic [MW-1:0]    s1_fy;
    logic [TAG_W-1:0] s1_tag;
    logic [2*N-1:0]   s1_prod;

    logic [LW-1:0]    log_sum;

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic             s2_exact;
    logic [LW-1:0]    s2_log;
    logic [TAG_W-1:0] s2_tag;
    logic [2*N-1:0]   s2_prod;

    logic [KW:0]      kp;
    logic [MW-1:0]    fp;
    logic [2*N-1:0]   approx_mag;
    logic [2*N-1:0]   result;

    logic             out_valid_q;
    logic [2*N-1:0]   out_p_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_exact_q;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // One's-complement magnitude: -1 maps to 0 and the most negative value to max positive.
    assign mag_x = in_x ^ {N{in_x[N-1]}};
    assign mag_y = in_y ^ {N{in_y[N-1]}};

    assign prod = {{N{in_x[N-1]}}, in_x} * {{N{in_y[N-1]}}, in_y};

    qlm_lod_enc #(
        .N  (N),
        .MW (MW)
    ) u_lod_x (
        .mag  (mag_x),
        .zero (zero_x),
        .k    (k_x),
        .f    (f_x)
    );

    qlm_lod_enc #(
        .N  (N),
        .MW (MW)
    ) u_lod_y (
        .mag  (mag_y),
        .zero (zero_y),
        .k    (k_y),
        .f    (f_y)
    );

    assign log_sum = LW'({s1_kx, s1_fx}) + LW'({s1_ky, s1_fy});

    assign kp = s2_log[LW-1:MW];
    assign fp = s2_log[MW-1:0];

    // Antilog: restore the implicit leading one, shift by the integer part, drop the fraction.
    assign approx_mag = (2*N)'((PW'({1'b1, fp}) << kp) >> MW);

    always_comb begin
        result = '0;
        if (s2_exact) begin
            result = s2_prod;
        end else if (!s2_zero) begin
            result = approx_mag ^ {(2*N){s2_sign}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_tag_q   <= '0;
            out_exact_q <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                out_p_q     <= result;
                out_tag_q   <= s2_tag;
                out_exact_q <= s2_exact;
            end
        end
    end

    // Payload registers need no reset: their valid bits gate every use downstream.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign  <= in_x[N-1] ^ in_y[N-1];
            s1_zero  <= zero_x | zero_y;
            s1_exact <= in_exact;
            s1_kx    <= k_x;
            s1_ky    <= k_y;
            s1_fx    <= f_x;
            s1_fy    <= f_y;
            s1_tag   <= in_tag;
            // Only capture the full product when it will be used, to keep the register quiet.
            s1_prod  <= in_exact ? prod : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && s1_valid) begin
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_exact <= s1_exact;
            s2_log   <= log_sum;
            s2_tag   <= s1_tag;
            s2_prod  <= s1_prod;
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;
    assign out_exact = out_exact_q;

endmodule

// File: tb/tb_qlm_pipe_mult.sv
// Self-checking bench for qlm_pipe_mult: directed vectors, stall/reset sequences and a
// randomized stream scored against an arithmetic reference model.
module tb_qlm_pipe_mult;

    localparam int unsigned N  = 8;
    localparam int unsigned MW = 4;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_x = '0;
    logic [N-1:0]  in_y = '0;
    logic          in_exact = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*N-1:0] out_p;
    logic [TW-1:0] out_tag;
    logic          out_exact;

    qlm_pipe_mult #(
        .N     (N),
        .MW    (MW),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_exact  (in_exact),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   x;
        logic [N-1:0]   y;
        logic           ex;
        logic [TW-1:0]  tag;
        logic [2*N-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*N-1:0] p;
        logic [TW-1:0]  tag;
        logic           ex;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: floor(log2) and fractional mantissa computed numerically, then 2^(sum).
    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic ex);
        longint sx, sy, a, b, fa, fb, l, kp, fp, m;
        int ka, kb;
        logic [2*N-1:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (ex) return (2*N)'(sx * sy);
        a = (sx < 0) ? -sx - 1 : sx;
        b = (sy < 0) ? -sy - 1 : sy;
        if (a == 0 || b == 0) return '0;
        ka = 0;
        while ((longint'(1) << (ka + 1)) <= a) ka++;
        kb = 0;
        while ((longint'(1) << (kb + 1)) <= b) kb++;
        fa = ((a - (longint'(1) << ka)) * (longint'(1) << MW)) / (longint'(1) << ka);
        fb = ((b - (longint'(1) << kb)) * (longint'(1) << MW)) / (longint'(1) << kb);
        l  = longint'(ka) * (longint'(1) << MW) + fa + longint'(kb) * (longint'(1) << MW) + fb;
        kp = l / (longint'(1) << MW);
        fp = l % (longint'(1) << MW);
        m  = (((longint'(1) << MW) + fp) * (longint'(1) << kp)) / (longint'(1) << MW);
        r  = (2*N)'(m);
        return ((sx < 0) != (sy < 0)) ? ~r : r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_front(input string name);
        if (sb.size() == 0) begin
            chk({name, "_spurious_valid"}, 64'(out_valid), 64'd0);
        end else begin
            chk({name, "_p"}, 64'(out_p), 64'(sb[0].p));
            chk({name, "_tag"}, 64'(out_tag), 64'(sb[0].tag));
            chk({name, "_exact"}, 64'(out_exact), 64'(sb[0].ex));
        end
    endtask

    // Single isolated operation on an empty pipeline: checks latency and payload.
    task automatic run_one(input vec_t v, input string name);
        int lat;
        in_x      = v.x;
        in_y      = v.y;
        in_exact  = v.ex;
        in_tag    = v.tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd3);
        chk({name, "_p"}, 64'(out_p), 64'(v.p));
        chk({name, "_tag"}, 64'(out_tag), 64'(v.tag));
        chk({name, "_exact"}, 64'(out_exact), 64'(v.ex));
        tick();
    endtask

    initial begin
        vec_t tbl[$];
        vec_t ops[4];
        vec_t v;
        int   idx, got, stall, stale;
        bit   seen, acc;

        tbl.push_back('{8'd3,   8'd5,   1'b0, 4'h1, 16'h000E});
        tbl.push_back('{8'hFD,  8'd5,   1'b0, 4'h2, 16'hFFF5});
        tbl.push_back('{8'h80,  8'h7F,  1'b0, 4'h3, 16'hC3FF});
        tbl.push_back('{8'h80,  8'h7F,  1'b1, 4'h4, 16'hC080});
        tbl.push_back('{8'd0,   8'd77,  1'b0, 4'h5, 16'h0000});
        tbl.push_back('{8'hFF,  8'd77,  1'b0, 4'h6, 16'h0000});
        tbl.push_back('{8'd7,   8'd7,   1'b1, 4'h7, 16'h0031});
        tbl.push_back('{8'hFB,  8'hFA,  1'b1, 4'h8, 16'h001E});
        tbl.push_back('{8'd5,   8'hFA,  1'b0, 4'h9, 16'hFFE7});

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_exact", 64'(out_exact), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        foreach (tbl[i]) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back ops with the consumer stalled for 5 cycles after the first result
        for (int i = 0; i < 4; i++) begin
            ops[i].x   = N'($urandom);
            ops[i].y   = N'($urandom);
            ops[i].ex  = (i == 2);
            ops[i].tag = TW'(i + 10);
            ops[i].p   = model(ops[i].x, ops[i].y, ops[i].ex);
        end
        sb.delete();
        idx = 0; got = 0; stall = 0; seen = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (out_valid) seen = 1;
            out_ready = !(seen && stall < 5);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                in_x     = ops[idx].x;
                in_y     = ops[idx].y;
                in_exact = ops[idx].ex;
                in_tag   = ops[idx].tag;
            end
            #1;
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                check_front("stall_hold");
                stall++;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_front("stall_drain");
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back('{ops[idx].p, ops[idx].tag, ops[idx].ex});
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("stall_results", 64'(got), 64'd4);
        chk("stall_cycles", 64'(stall), 64'd5);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = N'($urandom); in_y = N'($urandom); in_exact = 1'b0; in_tag = TW'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 64'd0);
        v = '{8'd3, 8'd5, 1'b0, 4'hA, 16'h000E};
        run_one(v, "post_rst");

        // Randomized stream against the reference model
        sb.delete();
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_x      = N'($urandom);
            in_y      = N'($urandom);
            in_exact  = ($urandom_range(0, 3) == 0);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                check_front("rnd");
                if (out_ready && sb.size() != 0) void'(sb.pop_front());
            end
            @(posedge clk);
            #1;
            if (acc) sb.push_back('{model(in_x, in_y, in_exact), in_tag, in_exact});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                check_front("rnd_drain");
                if (sb.size() != 0) void'(sb.pop_front());
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_sb_empty", 64'(sb.size()), 64'd0);
        chk("rnd_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
